// File: rtl/quad_cost_pkg.sv
// Shared constants for the quadratic cost evaluator: FSM state codes, default
// fixed-point format and default-width saturation limits.
package quad_cost_pkg;

  localparam int unsigned DefFrac = 8;
  localparam int unsigned DefOutW = 32;

  localparam logic [DefOutW-1:0] QMaxDef = {1'b0, {(DefOutW - 1){1'b1}}};
  localparam logic [DefOutW-1:0] QMinDef = {1'b1, {(DefOutW - 1){1'b0}}};

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StDiff = 3'd1;
  localparam state_t StSqr  = 3'd2;
  localparam state_t StWgt  = 3'd3;
  localparam state_t StRed  = 3'd4;
  localparam state_t StBias = 3'd5;
  localparam state_t StDone = 3'd6;

endpackage

// File: rtl/qmul_sat.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC
// (rounds toward -inf), then saturation back to W bits.
module qmul_sat #(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p,
  output logic         ovf
);

  localparam int unsigned PW = 2 * W;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic                 in_range;

  assign prod    = PW'($signed(a)) * PW'($signed(b));
  assign shifted = prod >>> FRAC;

  // Result fits when all bits from the W-1 sign position upward agree.
  assign in_range = (&shifted[PW-1:W-1]) | ~(|shifted[PW-1:W-1]);
  assign ovf      = ~in_range;
  assign p        = in_range ? shifted[W-1:0] :
                    (shifted[PW-1] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}});

endmodule

// File: rtl/quad_cost_eval.sv
// Multi-cycle evaluator of z = sum_i w_i*(x_i - o_i)^2 + bias with saturating
// fixed-point arithmetic and a sticky per-transaction overflow flag.
module quad_cost_eval
  import quad_cost_pkg::*;
#(
  parameter int unsigned N_DIM = 4,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = DefOutW,
  parameter int unsigned FRAC  = DefFrac
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_DIM*IN_W-1:0] x_in,
  input  logic [N_DIM*IN_W-1:0] off_in,
  input  logic [N_DIM*IN_W-1:0] wgt_in,
  input  logic [OUT_W-1:0]      bias_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      z_out,
  output logic                  overflow
);

  localparam int unsigned Log2N   = $clog2(N_DIM);
  localparam int unsigned NPad    = 1 << Log2N;
  localparam logic [4:0]  LastLvl = 5'((Log2N == 0) ? 0 : Log2N - 1);

  localparam logic [OUT_W-1:0] QMax = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] QMin = {1'b1, {(OUT_W - 1){1'b0}}};

  // Returns {overflow, saturated value} from a one-bit-wider raw result.
  function automatic logic [OUT_W:0] sat_fix(input logic [OUT_W:0] s);
    if (s[OUT_W] != s[OUT_W-1]) return {1'b1, s[OUT_W] ? QMin : QMax};
    return {1'b0, s[OUT_W-1:0]};
  endfunction

  function automatic logic [OUT_W:0] sat_add(input logic [OUT_W-1:0] a,
                                             input logic [OUT_W-1:0] b);
    return sat_fix({a[OUT_W-1], a} + {b[OUT_W-1], b});
  endfunction

  function automatic logic [OUT_W:0] sat_sub(input logic [OUT_W-1:0] a,
                                             input logic [OUT_W-1:0] b);
    return sat_fix({a[OUT_W-1], a} - {b[OUT_W-1], b});
  endfunction

  state_t                         state_q, state_d;
  logic [4:0]                     lvl_q, lvl_d;
  logic [N_DIM-1:0][IN_W-1:0]     x_q, x_d, o_q, o_d, w_q, w_d;
  logic [OUT_W-1:0]               bias_q, bias_d;
  logic [N_DIM-1:0][OUT_W-1:0]    d_q, d_d, sq_q, sq_d;
  logic [NPad-1:0][OUT_W-1:0]     red_q, red_d;
  logic [OUT_W-1:0]               z_q, z_d;
  logic                           ovf_q, ovf_d;
  logic                           valid_q, valid_d;

  logic [N_DIM-1:0][OUT_W-1:0]    w_ext, sq_p, wt_p;
  logic [N_DIM-1:0]               sq_ovf, wt_ovf;

  for (genvar i = 0; i < N_DIM; i++) begin : g_mul
    assign w_ext[i] = OUT_W'($signed(w_q[i]));

    qmul_sat #(
      .W    (OUT_W),
      .FRAC (FRAC)
    ) u_sq (
      .a   (d_q[i]),
      .b   (d_q[i]),
      .p   (sq_p[i]),
      .ovf (sq_ovf[i])
    );

    qmul_sat #(
      .W    (OUT_W),
      .FRAC (FRAC)
    ) u_wt (
      .a   (w_ext[i]),
      .b   (sq_q[i]),
      .p   (wt_p[i]),
      .ovf (wt_ovf[i])
    );
  end

  always_comb begin
    logic [OUT_W:0] t;
    t       = '0;
    state_d = state_q;
    lvl_d   = lvl_q;
    x_d     = x_q;
    o_d     = o_q;
    w_d     = w_q;
    bias_d  = bias_q;
    d_d     = d_q;
    sq_d    = sq_q;
    red_d   = red_q;
    z_d     = z_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = x_in;
          o_d     = off_in;
          w_d     = wgt_in;
          bias_d  = bias_in;
          ovf_d   = 1'b0;
          state_d = StDiff;
        end
      end
      StDiff: begin
        for (int i = 0; i < N_DIM; i++) begin
          t      = sat_sub(OUT_W'($signed(x_q[i])), OUT_W'($signed(o_q[i])));
          d_d[i] = t[OUT_W-1:0];
          ovf_d  = ovf_d | t[OUT_W];
        end
        state_d = StSqr;
      end
      StSqr: begin
        sq_d    = sq_p;
        ovf_d   = ovf_d | (|sq_ovf);
        state_d = StWgt;
      end
      StWgt: begin
        // Tree leaves beyond N_DIM stay zero so they do not disturb the sum.
        red_d = '0;
        for (int i = 0; i < N_DIM; i++) red_d[i] = wt_p[i];
        ovf_d   = ovf_d | (|wt_ovf);
        lvl_d   = '0;
        state_d = (Log2N == 0) ? StBias : StRed;
      end
      StRed: begin
        red_d = '0;
        for (int i = 0; i < NPad / 2; i++) begin
          t        = sat_add(red_q[2*i], red_q[2*i+1]);
          red_d[i] = t[OUT_W-1:0];
          ovf_d    = ovf_d | t[OUT_W];
        end
        lvl_d = lvl_q + 5'd1;
        if (lvl_q == LastLvl) state_d = StBias;
      end
      StBias: begin
        t       = sat_add(red_q[0], bias_q);
        z_d     = t[OUT_W-1:0];
        ovf_d   = ovf_d | t[OUT_W];
        valid_d = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lvl_q   <= '0;
      x_q     <= '0;
      o_q     <= '0;
      w_q     <= '0;
      bias_q  <= '0;
      d_q     <= '0;
      sq_q    <= '0;
      red_q   <= '0;
      z_q     <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      x_q     <= x_d;
      o_q     <= o_d;
      w_q     <= w_d;
      bias_q  <= bias_d;
      d_q     <= d_d;
      sq_q    <= sq_d;
      red_q   <= red_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = valid_q;
  assign z_out     = z_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_quad_cost_eval.sv
// Directed bench for quad_cost_eval: table of N_DIM=4 vectors plus hand
// sequences for stall, mid-transaction reset and N_DIM=3 / N_DIM=1 builds.
module tb_quad_cost_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v4, rdy4, ov4, ordy4, of4;
  logic [63:0] x4, o4, w4;
  logic [31:0] b4, z4;

  logic        v3, rdy3, ov3, ordy3, of3;
  logic [47:0] x3, o3, w3;
  logic [31:0] b3, z3;

  logic        v1, rdy1, ov1, ordy1, of1;
  logic [15:0] x1, o1, w1;
  logic [31:0] b1, z1;

  quad_cost_eval #(.N_DIM(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .x_in(x4), .off_in(o4),
    .wgt_in(w4), .bias_in(b4), .out_valid(ov4), .out_ready(ordy4), .z_out(z4), .overflow(of4)
  );

  quad_cost_eval #(.N_DIM(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .x_in(x3), .off_in(o3),
    .wgt_in(w3), .bias_in(b3), .out_valid(ov3), .out_ready(ordy3), .z_out(z3), .overflow(of3)
  );

  quad_cost_eval #(.N_DIM(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .x_in(x1), .off_in(o1),
    .wgt_in(w1), .bias_in(b1), .out_valid(ov1), .out_ready(ordy1), .z_out(z1), .overflow(of1)
  );

  typedef struct {
    string       name;
    logic [63:0] x;
    logic [63:0] o;
    logic [63:0] w;
    logic [31:0] bias;
    logic [31:0] z;
    logic        ovf;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_lat(input int which, output int lat);
    logic v;
    lat = 0;
    v   = 1'b0;
    while (!v && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      v = (which == 4) ? ov4 : ((which == 3) ? ov3 : ov1);
    end
  endtask

  // Accepts one operand set, scrambles the operand ports, checks the result.
  task automatic run4(input vec_t v);
    int lat;
    @(negedge clk);
    x4 = v.x;
    o4 = v.o;
    w4 = v.w;
    b4 = v.bias;
    v4 = 1'b1;
    check({v.name, " in_ready"}, 64'(rdy4), 64'd1);
    @(posedge clk);
    #1;
    v4 = 1'b0;
    x4 = {$urandom, $urandom};
    o4 = {$urandom, $urandom};
    w4 = {$urandom, $urandom};
    b4 = $urandom;
    wait_lat(4, lat);
    check({v.name, " latency"}, 64'(lat), 64'd6);
    check({v.name, " z"}, 64'(z4), 64'(v.z));
    check({v.name, " ovf"}, 64'(of4), 64'(v.ovf));
  endtask

  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    logic seen;

    vecs[0] = '{"base", 64'h0080_FF00_0100_0300, 64'h0000_FE00_0000_0200,
                64'h0400_0100_0100_0100, 32'hFFFF_FB00, 32'hFFFF_FF00, 1'b0};
    vecs[1] = '{"x_eq_o", 64'h0000_FE00_0000_0200, 64'h0000_FE00_0000_0200,
                64'h0400_0100_0100_0100, 32'hFFFF_FB00, 32'hFFFF_FB00, 1'b0};
    vecs[2] = '{"pos_sat", 64'h7FFF_7FFF_7FFF_7FFF, 64'h8000_8000_8000_8000,
                64'h7FFF_7FFF_7FFF_7FFF, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[3] = '{"ovf_clear", 64'h0080_FF00_0100_0300, 64'h0000_FE00_0000_0200,
                64'h0400_0100_0100_0100, 32'hFFFF_FB00, 32'hFFFF_FF00, 1'b0};
    vecs[4] = '{"neg_sat", 64'h7FFF_7FFF_7FFF_7FFF, 64'h8000_8000_8000_8000,
                64'h8000_8000_8000_8000, 32'h0000_0000, 32'h8000_0000, 1'b1};
    // (1/16)^2 = 1 LSB, times -0.5 gives -0.5 LSB which floors to -1 LSB.
    vecs[5] = '{"trunc", 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0000,
                64'h0000_0000_0000_FF80, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{"bias_only", 64'h1234_0100_FF00_0300, 64'h1234_0100_FF00_0300,
                64'h7FFF_7FFF_7FFF_7FFF, 32'h0001_2345, 32'h0001_2345, 1'b0};

    rst_n = 1'b0;
    v4 = 1'b0; x4 = '0; o4 = '0; w4 = '0; b4 = '0; ordy4 = 1'b1;
    v3 = 1'b0; x3 = '0; o3 = '0; w3 = '0; b3 = '0; ordy3 = 1'b1;
    v1 = 1'b0; x1 = '0; o1 = '0; w1 = '0; b1 = '0; ordy1 = 1'b1;

    #1;
    check("rst out_valid", 64'(ov4), 64'd0);
    check("rst z_out", 64'(z4), 64'd0);
    check("rst overflow", 64'(of4), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel in_ready", 64'(rdy4), 64'd1);

    for (int i = 0; i < 7; i++) begin
      run4(vecs[i]);
      @(posedge clk);
      #1;
    end

    // Consumer stalls for five cycles in DONE.
    ordy4 = 1'b0;
    run4(vecs[0]);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall out_valid", 64'(ov4), 64'd1);
      check("stall z", 64'(z4), 64'hFFFF_FF00);
      check("stall in_ready", 64'(rdy4), 64'd0);
    end
    ordy4 = 1'b1;
    @(posedge clk);
    #1;
    check("hs out_valid", 64'(ov4), 64'd0);
    check("hs in_ready", 64'(rdy4), 64'd1);

    // Reset asserted while the adder tree is mid-flight.
    @(negedge clk);
    x4 = vecs[1].x; o4 = vecs[1].o; w4 = vecs[1].w; b4 = vecs[1].bias;
    v4 = 1'b1;
    @(posedge clk);
    #1;
    v4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort z async", 64'(z4), 64'd0);
    check("abort out_valid async", 64'(ov4), 64'd0);
    check("abort overflow async", 64'(of4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort in_ready", 64'(rdy4), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      seen = seen | ov4;
    end
    check("abort no out_valid", 64'(seen), 64'd0);

    // N_DIM=3: 1^2 + 2^2 + 3^2 = 14.0.
    @(negedge clk);
    x3 = 48'h0300_0200_0100;
    o3 = '0;
    w3 = 48'h0100_0100_0100;
    b3 = '0;
    v3 = 1'b1;
    check("d3 in_ready", 64'(rdy3), 64'd1);
    @(posedge clk);
    #1;
    v3 = 1'b0;
    x3 = {$urandom, 16'(0)};
    wait_lat(3, lat);
    check("d3 latency", 64'(lat), 64'd6);
    check("d3 z", 64'(z3), 64'h0000_0E00);
    check("d3 ovf", 64'(of3), 64'd0);

    // N_DIM=1: no reduction levels, 2^2 = 4.0.
    @(negedge clk);
    x1 = 16'h0200;
    o1 = '0;
    w1 = 16'h0100;
    b1 = '0;
    v1 = 1'b1;
    check("d1 in_ready", 64'(rdy1), 64'd1);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    x1 = 16'h7ABC;
    wait_lat(1, lat);
    check("d1 latency", 64'(lat), 64'd4);
    check("d1 z", 64'(z1), 64'h0000_0400);
    check("d1 ovf", 64'(of1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
